// File: rtl/riscv_defines.sv
// Shared definitions for the load/store path: `DATA_WIDTH, funct3 width codes,
// LSU FSM state encoding, access-size decode and misalignment detection.
// No ports; imported with "import riscv_defines::*".
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package riscv_defines;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_t;

  // Unsupported codes fall through to a full-word access.
  function automatic acc_size_t access_size(input logic is_store, input logic [2:0] f3);
    if (f3 == F3_B || (!is_store && f3 == F3_BU)) return SZ_B;
    else if (f3 == F3_H || (!is_store && f3 == F3_HU)) return SZ_H;
    else return SZ_W;
  endfunction

  function automatic logic is_misaligned(input acc_size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_H:    return lo[0];
      SZ_W:    return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: combinational read, write on rising edge when
// i_we is high. Contents are not reset.
// Ports: i_clk, i_we, i_addr (word index), i_data (write data), o_data (read data).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module data_memory #(
  parameter  int MEM_SIZE = 1024,
  localparam int AW       = $clog2(MEM_SIZE)
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_addr,
  input  logic [`DATA_WIDTH-1:0] i_data,
  output logic [`DATA_WIDTH-1:0] o_data
);

  logic [`DATA_WIDTH-1:0] mem [MEM_SIZE];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_data;
  end

  assign o_data = mem[i_addr];

endmodule

// File: rtl/lsu_align.sv
// Lane steering for the LSU: extracts and extends a load lane from a memory
// word, and merges a store byte/half into a memory word (read-modify-write).
// Ports: addr_lo/size/is_unsigned select lane; word = memory word; wdata = store
// data; load_data = extended load result; merged = word with store lane replaced.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module lsu_align
  import riscv_defines::*;
(
  input  logic [1:0]             addr_lo,
  input  acc_size_t              size,
  input  logic                   is_unsigned,
  input  logic [`DATA_WIDTH-1:0] word,
  input  logic [`DATA_WIDTH-1:0] wdata,
  output logic [`DATA_WIDTH-1:0] load_data,
  output logic [`DATA_WIDTH-1:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v    = word[{addr_lo, 3'b000} +: 8];
    half_v    = word[{addr_lo[1], 4'b0000} +: 16];
    load_data = word;
    merged    = word;
    case (size)
      SZ_B: begin
        load_data = {{(`DATA_WIDTH-8){~is_unsigned & byte_v[7]}}, byte_v};
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data = {{(`DATA_WIDTH-16){~is_unsigned & half_v[15]}}, half_v};
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one load/store per handshake, byte/half/word with
// sign/zero extension, sub-word stores by read-modify-write, o_done pulse.
// Ports: i_clk/i_rst; request i_valid/o_ready/i_is_store/i_funct3/i_addr/i_wdata;
// response o_done/o_rdata/o_misaligned; memory o_mem_we/o_mem_addr/o_mem_wdata/i_mem_rdata.
// Build option LSU_MISALIGN_TRAP_EN: misaligned accesses are suppressed and flagged;
// otherwise the low address bits are forced down to the access size.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module load_store_unit
  import riscv_defines::*;
#(
  parameter  int MEM_SIZE = 1024,
  localparam int AW       = $clog2(MEM_SIZE)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_is_store,
  input  logic [2:0]             i_funct3,
  input  logic [31:0]            i_addr,
  input  logic [`DATA_WIDTH-1:0] i_wdata,
  output logic                   o_done,
  output logic [`DATA_WIDTH-1:0] o_rdata,
  output logic                   o_misaligned,
  output logic                   o_mem_we,
  output logic [AW-1:0]          o_mem_addr,
  output logic [`DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [`DATA_WIDTH-1:0] i_mem_rdata
);

  lsu_state_t             state, state_nxt;
  logic                   r_store;
  logic [2:0]             r_f3;
  logic [AW+1:0]          r_addr;
  logic [`DATA_WIDTH-1:0] r_wdata, r_rdata, r_merged;
  acc_size_t              in_size, r_size;
  logic                   accept, trap;
  logic [1:0]             lo_fix;
  logic [`DATA_WIDTH-1:0] load_data, merged;

  // Upper address bits do not reach the memory: the word index wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_addr[31:AW+2];

  assign accept  = i_valid && (state == ST_IDLE);
  assign in_size = access_size(i_is_store, i_funct3);
  assign r_size  = access_size(r_store, r_f3);

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_mis;
  assign trap   = is_misaligned(in_size, i_addr[1:0]);
  assign lo_fix = i_addr[1:0];
`else
  assign trap = 1'b0;
  // Round the address down to the access size instead of trapping.
  always_comb begin
    case (in_size)
      SZ_H:    lo_fix = {i_addr[1], 1'b0};
      SZ_W:    lo_fix = 2'b00;
      default: lo_fix = i_addr[1:0];
    endcase
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (trap)                            state_nxt = ST_RESP;
          else if (i_is_store && in_size == SZ_W) state_nxt = ST_WR;
          else                                 state_nxt = ST_RD;
        end
      end
      ST_RD:   state_nxt = r_store ? ST_WR : ST_RESP;
      ST_WR:   state_nxt = ST_RESP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  lsu_align u_align (
    .addr_lo     (r_addr[1:0]),
    .size        (r_size),
    .is_unsigned (r_f3[2]),
    .word        (i_mem_rdata),
    .wdata       (r_wdata),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_store  <= 1'b0;
      r_f3     <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_merged <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_mis    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        r_store <= i_is_store;
        r_f3    <= i_funct3;
        r_addr  <= {i_addr[AW+1:2], lo_fix};
        r_wdata <= i_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
        r_mis   <= trap;
`endif
      end
      // Memory read data is sampled at the end of RD for both loads and RMW.
      if (state == ST_RD) begin
        if (!r_store) r_rdata <= load_data;
        r_merged <= merged;
      end
    end
  end

  assign o_ready     = (state == ST_IDLE);
  assign o_done      = (state == ST_RESP);
  assign o_rdata     = r_rdata;
  assign o_mem_we    = (state == ST_WR);
  assign o_mem_addr  = r_addr[AW+1:2];
  assign o_mem_wdata = (r_size == SZ_W) ? r_wdata : r_merged;
`ifdef LSU_MISALIGN_TRAP_EN
  assign o_misaligned = o_done & r_mis;
`else
  assign o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with data_memory attached.
// Reference model: byte-level arithmetic on a word array, latency/write counts from the access rules.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_load_store_unit;

  localparam int MEM_SIZE = 1024;
  localparam int AW = $clog2(MEM_SIZE);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, valid = 1'b0, ready, is_store = 1'b0;
  logic [2:0]    funct3 = 3'b0;
  logic [31:0]   addr = 32'h0, wdata = 32'h0;
  logic          done, misaligned, mem_we;
  logic [31:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_is_store(is_store), .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
    .o_done(done), .o_rdata(rdata), .o_misaligned(misaligned),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  data_memory #(.MEM_SIZE(MEM_SIZE)) u_mem (
    .i_clk(clk), .i_we(mem_we), .i_addr(mem_addr), .i_data(mem_wdata), .o_data(mem_rdata)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] model_mem [MEM_SIZE];
  logic [31:0] last_rdata = 32'h0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  function automatic int nbytes(input bit st, input logic [2:0] f3);
    if (f3 == 3'b000 || (!st && f3 == 3'b100)) return 1;
    if (f3 == 3'b001 || (!st && f3 == 3'b101)) return 2;
    return 4;
  endfunction

  // Reference behaviour of one access; updates the model memory and last load result.
  task automatic model_exec(input bit st, input logic [2:0] f3, input logic [31:0] a_in,
                            input logic [31:0] wd, output int lat, output int wes,
                            output logic [31:0] rd, output logic mis);
    int n, idx, off;
    logic [31:0] a, w, mask, v;
    n = nbytes(st, f3);
    a = a_in;
    mis = 1'b0;
    if ((a % n) != 0 && TRAP) begin
      lat = 1; wes = 0; mis = 1'b1; rd = last_rdata;
      return;
    end
    a = a - (a % n);
    idx = int'((a >> 2) % MEM_SIZE);
    off = int'(a % 4);
    w = model_mem[idx];
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    if (!st) begin
      v = (w >> (8 * off)) & mask;
      if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~mask;
      last_rdata = v;
      rd = v; lat = 2; wes = 0;
    end else begin
      for (int b = 0; b < n; b++) w[8*(off+b) +: 8] = wd[8*b +: 8];
      model_mem[idx] = w;
      rd = last_rdata; lat = (n == 4) ? 2 : 3; wes = 1;
    end
  endtask

  // Drives one request and observes the response; hold keeps i_valid high while busy
  // with scrambled request fields, so a second accept would corrupt the result.
  task automatic drive(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold, output int lat,
                       output int wes, output logic [31:0] rd, output logic mis);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!ready && guard < 20) begin @(negedge clk); guard++; end
    if (!ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: o_ready=%0b required 1", ready);
    end
    valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    if (hold) begin addr = ~a; wdata = ~wd; end
    else valid = 1'b0;
    lat = 0; wes = 0; rd = rdata; mis = misaligned;
    for (int c = 1; c <= 10; c++) begin
      if (mem_we) wes++;
      if (done) begin lat = c; rd = rdata; mis = misaligned; break; end
      @(negedge clk);
    end
    valid = 1'b0;
    if (lat == 0) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: no o_done within 10 cycles");
    end
  endtask

  task automatic xfer(input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input bit hold,
                      output int lat, output int wes, output logic [31:0] rd, output logic mis,
                      output int e_lat, output int e_wes, output logic [31:0] e_rd, output logic e_mis);
    drive(st, f3, a, wd, hold, lat, wes, rd, mis);
    model_exec(st, f3, a, wd, e_lat, e_wes, e_rd, e_mis);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ready, done, misaligned, mem_we} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctrl: rdy/done/mis/we=%b required 1000", {ready, done, misaligned, mem_we});
    end
    n_checks++;
    if (rdata !== 32'h0 || mem_wdata !== 32'h0 || mem_addr !== '0) begin
      n_fail++; $display("FAIL reset_data: rdata=%h wdata=%h addr=%h required 0", rdata, mem_wdata, mem_addr);
    end
    last_rdata = 32'h0;
  endtask

  task automatic preload();
    int l, w, el, ew; logic [31:0] r, er, v; logic m, em;
    for (int i = 0; i < 16; i++) begin
      v = (i == 2) ? 32'h80FF_7F01 : $urandom;
      xfer(1'b1, 3'b010, 32'(i * 4), v, 1'b0, l, w, r, m, el, ew, er, em);
    end
  endtask

  task automatic test_lw_basic();
    int l, w, el, ew; logic [31:0] r, er; logic m, em;
    xfer(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, l, w, r, m, el, ew, er, em);
    n_checks++;
    if (l !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d required 2", l); end
    n_checks++;
    if (r !== 32'h80FF_7F01) begin n_fail++; $display("FAIL lw_data: got %h required 80ff7f01", r); end
  endtask

  task automatic test_subword_loads();
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] as  [4] = '{32'hB, 32'hB, 32'hA, 32'h8};
    logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    int l, w, el, ew; logic [31:0] r, er; logic m, em;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, f3s[i], as[i], 32'h0, 1'b0, l, w, r, m, el, ew, er, em);
      n_checks++;
      if (r !== exp[i] || l !== 2) begin
        n_fail++; $display("FAIL subload_%0d: data=%h lat=%0d required %h lat 2", i, r, l, exp[i]);
      end
    end
  endtask

  task automatic test_sb();
    int l, w, el, ew; logic [31:0] r, er; logic m, em;
    xfer(1'b1, 3'b000, 32'h9, 32'h1234_56AA, 1'b0, l, w, r, m, el, ew, er, em);
    n_checks++;
    if (l !== 3 || w !== 1) begin n_fail++; $display("FAIL sb_timing: lat=%0d we=%0d required 3/1", l, w); end
    xfer(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, l, w, r, m, el, ew, er, em);
    n_checks++;
    if (r !== 32'h80FF_AA01) begin n_fail++; $display("FAIL sb_readback: got %h required 80ffaa01", r); end
  endtask

  task automatic test_sh_sw_hold();
    int l, w, el, ew; logic [31:0] r, er; logic m, em;
    xfer(1'b1, 3'b001, 32'hA, 32'hCAFE_1234, 1'b1, l, w, r, m, el, ew, er, em);
    n_checks++;
    if (l !== 3 || w !== 1) begin n_fail++; $display("FAIL sh_hold_timing: lat=%0d we=%0d required 3/1", l, w); end
    xfer(1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF, 1'b1, l, w, r, m, el, ew, er, em);
    n_checks++;
    if (l !== 2 || w !== 1) begin n_fail++; $display("FAIL sw_hold_timing: lat=%0d we=%0d required 2/1", l, w); end
    xfer(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, l, w, r, m, el, ew, er, em);
    n_checks++;
    if (r !== 32'h1234_AA01) begin n_fail++; $display("FAIL sh_readback: got %h required 1234aa01", r); end
    xfer(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, l, w, r, m, el, ew, er, em);
    n_checks++;
    if (r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_readback: got %h required deadbeef", r); end
  endtask

  task automatic test_misaligned();
    int l, w, el, ew; logic [31:0] r, er; logic m, em;
    xfer(1'b0, 3'b010, 32'h6, 32'h0, 1'b0, l, w, r, m, el, ew, er, em);
    n_checks++;
    if (l !== el || w !== 0 || m !== em || r !== er) begin
      n_fail++; $display("FAIL misaligned_lw: lat=%0d we=%0d mis=%b data=%h required %0d/0/%b/%h", l, w, m, r, el, em, er);
    end
    xfer(1'b1, 3'b010, 32'h2, 32'h5555_AAAA, 1'b0, l, w, r, m, el, ew, er, em);
    xfer(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, l, w, r, m, el, ew, er, em);
    n_checks++;
    if (r !== er) begin n_fail++; $display("FAIL misaligned_sw_effect: word0=%h required %h", r, er); end
  endtask

  task automatic test_reset_mid_and_wrap();
    int l, w, el, ew, wes; logic [31:0] r, er; logic m, em;
    bit saw_done;
    @(negedge clk);
    while (!ready) @(negedge clk);
    valid = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h9; wdata = 32'h55;
    @(negedge clk);
    valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_in_rd: rdy=%b done=%b rdata=%h required 1/0/0", ready, done, rdata);
    end
    last_rdata = 32'h0;
    saw_done = 0; wes = 0;
    repeat (5) begin @(negedge clk); if (done) saw_done = 1; if (mem_we) wes++; end
    n_checks++;
    if (saw_done || wes != 0) begin n_fail++; $display("FAIL reset_no_done: done=%0b we=%0d required 0/0", saw_done, wes); end
    xfer(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, l, w, r, m, el, ew, er, em);
    n_checks++;
    if (r !== er) begin n_fail++; $display("FAIL reset_mem_intact: got %h required %h", r, er); end
    xfer(1'b0, 3'b010, 32'h1008, 32'h0, 1'b0, l, w, r, m, el, ew, er, em);
    n_checks++;
    if (r !== er) begin n_fail++; $display("FAIL wrap_load: got %h required %h", r, er); end
  endtask

  task automatic test_random();
    int l, w, el, ew; logic [31:0] r, er, a, wd; logic m, em; bit st; logic [2:0] f3;
    for (int i = 0; i < 120; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; a[11:6] = 6'h0;
      wd = $urandom;
      xfer(st, f3, a, wd, 1'($urandom_range(0, 1)), l, w, r, m, el, ew, er, em);
      n_checks++;
      if (l !== el || w !== ew || r !== er || m !== em) begin
        n_fail++;
        $display("FAIL random_%0d st=%0b f3=%0d a=%h: lat=%0d we=%0d data=%h mis=%b required %0d/%0d/%h/%b",
                 i, st, f3, a, l, w, r, m, el, ew, er, em);
      end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_lw_basic();
    test_subword_loads();
    test_sb();
    test_sh_sw_hold();
    test_misaligned();
    test_reset_mid_and_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
